// File: rtl/mem_agent_types_pkg.sv
// rtl/mem_agent_types_pkg.sv - shared types and constants for the DDR memory agent
// Holds the bus widths, the read window and the read-master state type.
package mem_agent_types;

   localparam int AXI_MASTER_DATA_WIDTH  = 64;
   localparam int AXI_MASTER_ADDR_WIDTH  = 32;
   localparam int AXI_RD_OUTSTANDING_MAX = 16;
   localparam int AXI_BURST_BEATS        = 16;
   localparam int DEBG_COUNTER_BITS      = 32;

   // Read window: [AXI_RD_ADDR_BASE, AXI_RD_ADDR_HIGH)
   localparam logic [31:0] AXI_RD_ADDR_BASE = 32'h4000_0000;
   localparam logic [31:0] AXI_RD_ADDR_HIGH = 32'h5000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } rd_state_t;

   // Write side of the downstream FIFO: wrreq/data driven by the agent, full returned.
   typedef struct packed {
      logic                             wrreq;
      logic                             full;
      logic [AXI_MASTER_DATA_WIDTH-1:0] data;
   } fifo_wr_if_t;

endpackage

// File: rtl/mem_rd_addr_gen.sv
// rtl/mem_rd_addr_gen.sv - burst address stepping with window wrap and burst countdown
// Ports: clk/rst; load + load_addr/load_bursts start a command; step advances one burst;
//        addr is the current burst address, bursts_left the remaining count, last_burst
//        flags that the current burst is the final one.
module mem_rd_addr_gen
   import mem_agent_types::*;
#(
   parameter int ADDR_WIDTH  = AXI_MASTER_ADDR_WIDTH,
   parameter int BURST_BEATS = AXI_BURST_BEATS,
   parameter int CNT_W       = 29
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [CNT_W-1:0]      load_bursts,
   input  logic                  step,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [CNT_W-1:0]      bursts_left,
   output logic                  last_burst
);

   localparam logic [ADDR_WIDTH:0] STEP_BYTES = (ADDR_WIDTH+1)'(BURST_BEATS * 8);

   // One extra bit so a step past the top of the address space still compares as >= HIGH.
   logic [ADDR_WIDTH:0] addr_inc;

   assign addr_inc   = {1'b0, addr} + STEP_BYTES;
   assign last_burst = (bursts_left == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         addr        <= ADDR_WIDTH'(AXI_RD_ADDR_BASE);
         bursts_left <= '0;
      end else if (load) begin
         addr        <= load_addr;
         bursts_left <= load_bursts;
      end else if (step) begin
         if (addr_inc >= (ADDR_WIDTH+1)'(AXI_RD_ADDR_HIGH))
            addr <= ADDR_WIDTH'(AXI_RD_ADDR_BASE);
         else
            addr <= addr_inc[ADDR_WIDTH-1:0];
         bursts_left <= bursts_left - CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_rd_agent.sv
// rtl/mem_rd_agent.sv - AXI4 read master streaming fixed INCR bursts into a write FIFO
// Ports: cmd_* command handshake (addr, beats); busy/done status; m_axi_ar*/m_axi_r* AXI4
//        read channels; fifo_wrreq/fifo_full/fifo_data downstream FIFO write side;
//        dbg_* free-running debug counters cleared only by rst.
module mem_rd_agent
   import mem_agent_types::*;
#(
   parameter int DATA_WIDTH      = AXI_MASTER_DATA_WIDTH,
   parameter int ADDR_WIDTH      = AXI_MASTER_ADDR_WIDTH,
   parameter int OUTSTANDING_MAX = AXI_RD_OUTSTANDING_MAX,
   parameter int BURST_BEATS     = AXI_BURST_BEATS
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [ADDR_WIDTH-1:0]        cmd_addr,
   input  logic [31:0]                  cmd_beats,
   output logic                         busy,
   output logic                         done,
   output logic [ADDR_WIDTH-1:0]        m_axi_araddr,
   output logic [7:0]                   m_axi_arlen,
   output logic [2:0]                   m_axi_arsize,
   output logic [1:0]                   m_axi_arburst,
   output logic                         m_axi_arvalid,
   input  logic                         m_axi_arready,
   input  logic [DATA_WIDTH-1:0]        m_axi_rdata,
   input  logic [1:0]                   m_axi_rresp,
   input  logic                         m_axi_rlast,
   input  logic                         m_axi_rvalid,
   output logic                         m_axi_rready,
   output logic                         fifo_wrreq,
   input  logic                         fifo_full,
   output logic [DATA_WIDTH-1:0]        fifo_data,
   output logic [DEBG_COUNTER_BITS-1:0] dbg_bursts,
   output logic [DEBG_COUNTER_BITS-1:0] dbg_beats,
   output logic [DEBG_COUNTER_BITS-1:0] dbg_stall,
   output logic [DEBG_COUNTER_BITS-1:0] dbg_err
);

   localparam int         BURST_BYTES = BURST_BEATS * 8;
   localparam int         BEAT_SHIFT  = $clog2(BURST_BEATS);
   localparam int         CNT_W       = 33 - BEAT_SHIFT;
   localparam logic [4:0] OUT_MAX     = 5'(OUTSTANDING_MAX);

   rd_state_t             state;
   logic                  arvalid_q;
   logic [4:0]            outstanding;
   logic [4:0]            outstanding_next;
   logic [CNT_W-1:0]      bursts_left;
   logic                  last_burst;
   logic                  cmd_hs;
   logic                  cmd_in_range;
   logic                  cmd_load;
   logic [ADDR_WIDTH-1:0] cmd_base;
   logic [32:0]           beats_round;
   logic [CNT_W-1:0]      cmd_bursts;
   logic                  ar_hs;
   logic                  r_hs;
   logic                  rlast_hs;
   logic                  orphan_rlast;
   logic                  resp_err;
   logic                  range_err;

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

   // Command decode: align to a burst boundary and round the beat count up to whole bursts.
   assign cmd_hs       = cmd_valid & cmd_ready;
   assign cmd_base     = cmd_addr & ~ADDR_WIDTH'(BURST_BYTES - 1);
   assign cmd_in_range = (cmd_base >= ADDR_WIDTH'(AXI_RD_ADDR_BASE)) &&
                         (cmd_base <  ADDR_WIDTH'(AXI_RD_ADDR_HIGH));
   assign beats_round  = {1'b0, cmd_beats} + 33'(BURST_BEATS - 1);
   assign cmd_bursts   = beats_round[32:BEAT_SHIFT];
   assign cmd_load     = cmd_hs & cmd_in_range & (cmd_beats != '0);
   assign range_err    = cmd_hs & ~cmd_in_range;

   // arvalid is registered but drops combinationally with rst so a reset mid-burst never
   // leaves a request visible for the reset cycle.
   assign m_axi_arvalid = arvalid_q & ~rst;
   assign m_axi_arlen   = 8'(BURST_BEATS - 1);
   assign m_axi_arsize  = 3'b011;
   assign m_axi_arburst = 2'b01;

   // R path is pure wiring into the FIFO; error beats are still written.
   assign m_axi_rready = ~fifo_full;
   assign fifo_wrreq   = m_axi_rvalid & ~fifo_full;
   assign fifo_data    = m_axi_rdata;

   assign ar_hs        = m_axi_arvalid & m_axi_arready;
   assign r_hs         = m_axi_rvalid & m_axi_rready;
   assign rlast_hs     = r_hs & m_axi_rlast;
   assign resp_err     = r_hs & (m_axi_rresp != 2'b00);
   assign orphan_rlast = rlast_hs & ~ar_hs & (outstanding == '0);

   always_comb begin
      outstanding_next = outstanding;
      if (ar_hs && !rlast_hs)
         outstanding_next = outstanding + 5'd1;
      else if (rlast_hs && !ar_hs && outstanding != '0)
         outstanding_next = outstanding - 5'd1;
   end

   mem_rd_addr_gen #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .BURST_BEATS (BURST_BEATS),
      .CNT_W       (CNT_W)
   ) u_addr_gen (
      .clk         (clk),
      .rst         (rst),
      .load        (cmd_load),
      .load_addr   (cmd_base),
      .load_bursts (cmd_bursts),
      .step        (ar_hs),
      .addr        (m_axi_araddr),
      .bursts_left (bursts_left),
      .last_burst  (last_burst)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         arvalid_q   <= 1'b0;
         outstanding <= '0;
      end else begin
         outstanding <= outstanding_next;
         case (state)
            IDLE: begin
               if (cmd_load) begin
                  state     <= ISSUE;
                  arvalid_q <= (outstanding_next < OUT_MAX);
               end else if (cmd_hs) begin
                  state <= DONE;
               end
            end
            ISSUE: begin
               // A pending request only ever sees outstanding fall, so re-evaluating the
               // limit here never withdraws an arvalid that has not yet been accepted.
               if (ar_hs && last_burst) begin
                  state     <= DRAIN;
                  arvalid_q <= 1'b0;
               end else begin
                  arvalid_q <= (outstanding_next < OUT_MAX);
               end
            end
            DRAIN: begin
               if (outstanding == '0)
                  state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dbg_bursts <= '0;
         dbg_beats  <= '0;
         dbg_stall  <= '0;
         dbg_err    <= '0;
      end else begin
         dbg_bursts <= dbg_bursts + DEBG_COUNTER_BITS'(ar_hs);
         dbg_beats  <= dbg_beats + DEBG_COUNTER_BITS'(r_hs);
         dbg_stall  <= dbg_stall + DEBG_COUNTER_BITS'(m_axi_rvalid & fifo_full);
         dbg_err    <= dbg_err + DEBG_COUNTER_BITS'(range_err)
                               + DEBG_COUNTER_BITS'(resp_err)
                               + DEBG_COUNTER_BITS'(orphan_rlast);
      end
   end

endmodule

// File: tb/tb_mem_rd_agent.sv
// tb/tb_mem_rd_agent.sv - scoreboard bench for mem_rd_agent with an AXI read slave model
module tb_mem_rd_agent;

   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam longint      WIN  = 64'h1000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_beats = '0;
   logic        busy, done;
   logic [31:0] m_axi_araddr;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize;
   logic [1:0]  m_axi_arburst;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [63:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rlast;
   logic        m_axi_rvalid;
   logic        m_axi_rready;
   logic        fifo_wrreq;
   logic        fifo_full;
   logic [63:0] fifo_data;
   logic [31:0] dbg_bursts, dbg_beats, dbg_stall, dbg_err;

   int errors = 0;
   int checks = 0;

   // Scoreboard state
   logic [31:0] exp_ar[$];
   logic [63:0] exp_data[$];
   longint      exp_bursts = 0, exp_beats = 0, exp_stall = 0, exp_err = 0;
   int          exp_out = 0;

   // Slave model state
   logic [31:0] burst_q[$];
   int          beat_idx = 0;
   int          hold = 0;
   bit          inject_err = 0;
   int          ar_limit = 1000000;
   int          ar_acc = 0;
   bit          ar_rand = 0, r_rand = 0, full_rand = 0;

   mem_rd_agent dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_addr      (cmd_addr),
      .cmd_beats     (cmd_beats),
      .busy          (busy),
      .done          (done),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arlen   (m_axi_arlen),
      .m_axi_arsize  (m_axi_arsize),
      .m_axi_arburst (m_axi_arburst),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_rlast   (m_axi_rlast),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready),
      .fifo_wrreq    (fifo_wrreq),
      .fifo_full     (fifo_full),
      .fifo_data     (fifo_data),
      .dbg_bursts    (dbg_bursts),
      .dbg_beats     (dbg_beats),
      .dbg_stall     (dbg_stall),
      .dbg_err       (dbg_err)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [63:0] mem_word(input logic [31:0] a);
      return {a ^ 32'h5A5A_0F0F, a};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic chk_true(input string name, input bit cond);
      checks++;
      if (!cond) begin
         errors++;
         $display("FAIL %s: condition false, required true", name);
      end
   endtask

   // Reference: burst k of a command sits k*128 bytes past the aligned start, modulo the window.
   task automatic expect_cmd(input logic [31:0] addr, input int beats);
      logic [31:0] al, a;
      longint      off;
      int          nb;
      al = addr & 32'hFFFF_FF80;
      if (longint'(al) < longint'(BASE) || longint'(al) >= longint'(BASE) + WIN) begin
         exp_err++;
         return;
      end
      if (beats == 0) return;
      nb = (beats + 15) / 16;
      for (int k = 0; k < nb; k++) begin
         off = (longint'(al) - longint'(BASE) + longint'(k) * 128) % WIN;
         a   = BASE + 32'(off);
         exp_ar.push_back(a);
         for (int i = 0; i < 16; i++) exp_data.push_back(mem_word(a + 32'(i * 8)));
      end
      exp_bursts += nb;
      exp_beats  += nb * 16;
   endtask

   task automatic check_counters(input string tag);
      chk({tag, "_dbg_bursts"}, 64'(dbg_bursts), 64'(exp_bursts));
      chk({tag, "_dbg_beats"},  64'(dbg_beats),  64'(exp_beats));
      chk({tag, "_dbg_stall"},  64'(dbg_stall),  64'(exp_stall));
      chk({tag, "_dbg_err"},    64'(dbg_err),    64'(exp_err));
      chk({tag, "_ar_left"},    64'(exp_ar.size()),   64'd0);
      chk({tag, "_data_left"},  64'(exp_data.size()), 64'd0);
   endtask

   task automatic run_cmd(input string tag, input logic [31:0] addr, input int beats, output int lat);
      int n;
      bit seen;
      expect_cmd(addr, beats);
      n = 0;
      while (!cmd_ready && n < 100) begin
         @(posedge clk); #2;
         n++;
      end
      chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1;
      cmd_addr  = addr;
      cmd_beats = 32'(beats);
      @(posedge clk); #2;
      cmd_valid = 1'b0;
      lat  = 1;
      seen = 0;
      while (lat < 5000) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
         @(posedge clk); #2;
         lat++;
      end
      chk_true({tag, "_done_seen"}, seen);
      @(posedge clk); #2;
      chk({tag, "_done_pulse"}, 64'(done), 64'd0);
      check_counters(tag);
   endtask

   // AXI read slave: samples handshakes at negedge, drives the next cycle after posedge.
   initial begin
      bit          ar_f, r_f;
      logic [31:0] a;
      m_axi_arready = 1'b1;
      m_axi_rvalid  = 1'b0;
      m_axi_rlast   = 1'b0;
      m_axi_rresp   = 2'b00;
      m_axi_rdata   = '0;
      fifo_full     = 1'b0;
      forever begin
         @(negedge clk);
         ar_f = m_axi_arvalid && m_axi_arready;
         a    = m_axi_araddr;
         r_f  = m_axi_rvalid && m_axi_rready;
         @(posedge clk); #1;
         if (ar_f) begin
            burst_q.push_back(a);
            ar_acc++;
         end
         if (r_f && burst_q.size() > 0) begin
            if (m_axi_rresp != 2'b00) inject_err = 0;
            if (beat_idx == 15) begin
               beat_idx = 0;
               burst_q.delete(0);
            end else begin
               beat_idx++;
            end
         end
         if (hold > 0) hold--;
         if (!(m_axi_rvalid && !r_f))
            m_axi_rvalid = (burst_q.size() > 0) && (hold == 0) && (!r_rand || $urandom_range(0, 1) == 1);
         if (burst_q.size() > 0) begin
            m_axi_rdata = mem_word(burst_q[0] + 32'(beat_idx * 8));
            m_axi_rlast = (beat_idx == 15);
            m_axi_rresp = (inject_err && beat_idx == 5) ? 2'b10 : 2'b00;
         end else begin
            m_axi_rlast = 1'b0;
            m_axi_rresp = 2'b00;
         end
         m_axi_arready = (ar_acc < ar_limit) && (!ar_rand || $urandom_range(0, 1) == 1);
         fifo_full     = full_rand && ($urandom_range(0, 1) == 1);
      end
   end

   // Monitor: pops scoreboard entries whenever the DUT presents an AR or a FIFO write.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("rready_vs_full", 64'(m_axi_rready), 64'(!fifo_full));
         chk("wrreq_vs_rvalid", 64'(fifo_wrreq), 64'(m_axi_rvalid && !fifo_full));
         if (m_axi_arvalid && m_axi_arready) begin
            if (exp_ar.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ar: got araddr %0h required no request", m_axi_araddr);
            end else begin
               chk("araddr", 64'(m_axi_araddr), 64'(exp_ar.pop_front()));
            end
            chk("arlen",   64'(m_axi_arlen),   64'd15);
            chk("arsize",  64'(m_axi_arsize),  64'd3);
            chk("arburst", 64'(m_axi_arburst), 64'd1);
            exp_out++;
            chk_true("outstanding_limit", exp_out <= 16);
         end
         if (m_axi_rvalid && m_axi_rready && m_axi_rlast && exp_out > 0) exp_out--;
         if (fifo_wrreq) begin
            if (exp_data.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got %0h required no write", fifo_data);
            end else begin
               chk("fifo_data", fifo_data, exp_data.pop_front());
            end
         end
         if (m_axi_rvalid && fifo_full) exp_stall++;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      int          n;
      logic [31:0] ra;
      int          rb;

      // Reset values
      repeat (3) begin
         @(posedge clk); #2;
      end
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_done",      64'(done),      64'd0);
      chk("rst_arvalid",   64'(m_axi_arvalid), 64'd0);
      chk("rst_araddr",    64'(m_axi_araddr),  64'(BASE));
      chk("rst_dbg_err",   64'(dbg_err),   64'd0);
      rst = 1'b0;
      @(posedge clk); #2;

      // Single burst, minimum latency
      run_cmd("single", 32'h4000_0000, 16, lat);
      chk("single_latency", 64'(lat), 64'd19);
      chk("single_bursts", 64'(dbg_bursts), 64'd1);
      chk("single_beats",  64'(dbg_beats),  64'd16);

      // Outstanding limit with R held off
      ar_acc = 0;
      hold   = 100;
      fork
         run_cmd("limit", 32'h4000_0000, 512, lat);
         begin
            repeat (40) @(posedge clk);
            #3;
            chk("limit_ar_count_held", 64'(ar_acc), 64'd16);
            chk("limit_arvalid_low",   64'(m_axi_arvalid), 64'd0);
            chk("limit_busy",          64'(busy), 64'd1);
         end
      join
      chk("limit_ar_total", 64'(ar_acc), 64'd32);

      // Wrap at the top of the window
      run_cmd("wrap", 32'h4FFF_FF80, 32, lat);

      // Partial final burst and unaligned start
      run_cmd("round", 32'h4000_1234, 20, lat);

      // FIFO backpressure
      full_rand = 1;
      run_cmd("backpressure", 32'h4000_1000, 16, lat);
      full_rand = 0;

      // Error response then out-of-range command, then a zero-beat command
      inject_err = 1;
      exp_err++;
      run_cmd("resp_err", 32'h4000_2000, 16, lat);
      ar_acc = 0;
      run_cmd("range_err", 32'h3000_0000, 16, lat);
      chk("range_err_no_ar", 64'(ar_acc), 64'd0);
      chk("dbg_err_two", 64'(dbg_err), 64'd2);
      run_cmd("zero_beats", 32'h4000_3000, 0, lat);
      chk("zero_beats_no_ar", 64'(ar_acc), 64'd0);

      // Randomized commands
      for (int it = 0; it < 10; it++) begin
         ar_rand   = ($urandom_range(0, 1) == 1);
         r_rand    = ($urandom_range(0, 1) == 1);
         full_rand = ($urandom_range(0, 1) == 1);
         case ($urandom_range(0, 5))
            0:       ra = 32'h6000_0000 + 32'($urandom_range(0, 4095));
            1:       ra = BASE + 32'(WIN) - 32'($urandom_range(1, 3) * 128) + 32'($urandom_range(0, 127));
            default: ra = BASE + 32'($urandom_range(0, 2097151) * 128) + 32'($urandom_range(0, 127));
         endcase
         rb = int'($urandom_range(1, 70));
         run_cmd("random", ra, rb, lat);
      end
      ar_rand   = 0;
      r_rand    = 0;
      full_rand = 0;
      @(posedge clk); #2;

      // Reset in the middle of a command with 4 bursts outstanding
      ar_acc   = 0;
      ar_limit = 4;
      hold     = 100000;
      expect_cmd(32'h4000_0000, 256);
      cmd_valid = 1'b1;
      cmd_addr  = 32'h4000_0000;
      cmd_beats = 32'd256;
      @(posedge clk); #2;
      cmd_valid = 1'b0;
      n = 0;
      while (ar_acc < 4 && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      chk("midrst_ar_count", 64'(ar_acc), 64'd4);
      repeat (2) begin
         @(posedge clk); #2;
      end
      chk("midrst_busy_before", 64'(busy), 64'd1);
      chk("midrst_arvalid_before", 64'(m_axi_arvalid), 64'd1);
      rst = 1'b1;
      burst_q.delete();
      beat_idx = 0;
      hold = 0;
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      exp_ar.delete();
      exp_data.delete();
      exp_out = 0;
      #1;
      chk("midrst_arvalid_immediate", 64'(m_axi_arvalid), 64'd0);
      @(posedge clk); #2;
      chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("midrst_busy",      64'(busy),      64'd0);
      chk("midrst_done",      64'(done),      64'd0);
      chk("midrst_arvalid",   64'(m_axi_arvalid), 64'd0);
      chk("midrst_araddr",    64'(m_axi_araddr),  64'(BASE));
      chk("midrst_bursts",    64'(dbg_bursts), 64'd0);
      chk("midrst_beats",     64'(dbg_beats),  64'd0);
      chk("midrst_stall",     64'(dbg_stall),  64'd0);
      chk("midrst_err",       64'(dbg_err),    64'd0);
      exp_bursts = 0;
      exp_beats  = 0;
      exp_stall  = 0;
      exp_err    = 0;
      ar_limit   = 1000000;
      rst = 1'b0;
      @(posedge clk); #2;

      // Recovery after reset
      run_cmd("post_reset", 32'h4000_0200, 16, lat);
      chk("post_reset_latency", 64'(lat), 64'd19);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
